// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader.
//   ADDR_W / DATA_W  : instruction memory address and word widths
//   CNT_W            : width of the header word count (N-1)
//   BYTES_PER_WORD   : stream bytes per instruction word
//   state_t          : loader frame-parsing states
//   pack_word()      : assembles one instruction word from its three bytes
package loader_pkg;

    localparam int unsigned ADDR_W         = 12;
    localparam int unsigned DATA_W         = 19;
    localparam int unsigned CNT_W          = 12;
    localparam int unsigned BYTES_PER_WORD = 3;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        W0,
        W1,
        W2,
        CHK,
        DONE,
        ERR
    } state_t;

    // Little-endian word: only the low 3 bits of the top byte carry data.
    function automatic logic [DATA_W-1:0] pack_word(input logic [2:0] b2,
                                                    input logic [7:0] b1,
                                                    input logic [7:0] b0);
        return {b2, b1, b0};
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory signals of the program loader.
//   master : host side (drives byte_in/byte_valid, observes everything else)
//   slave  : loader side (accepts bytes, drives imem write port and status)
interface prog_loader_if #(
    parameter int unsigned ADDR_W = loader_pkg::ADDR_W,
    parameter int unsigned DATA_W = loader_pkg::DATA_W
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/word_packer.sv
// Assembles a 19-bit instruction word from three little-endian stream bytes.
//   clk, rst  : clock, synchronous active-high reset
//   byte_in   : current stream byte (the top byte, b2, is used directly)
//   load_b0   : capture byte_in as b0
//   load_b1   : capture byte_in as b1
//   word      : {byte_in[2:0], b1, b0}, valid while the b2 byte is presented
//   frame_ok  : byte_in[7:3] are zero, i.e. byte_in is a legal b2 byte
module word_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              load_b0,
    input  logic              load_b1,
    output logic [DATA_W-1:0] word,
    output logic              frame_ok
);

    logic [7:0] b0_q;
    logic [7:0] b1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            b0_q <= '0;
            b1_q <= '0;
        end else begin
            if (load_b0) b0_q <= byte_in;
            if (load_b1) b1_q <= byte_in;
        end
    end

    always_comb begin
        word     = pack_word(byte_in[2:0], b1_q, b0_q);
        frame_ok = (byte_in[7:3] == 5'd0);
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a framed byte image (header, packed
// 19-bit words, XOR checksum), writes each word to instruction memory from
// address 0, and releases the core once the checksum verifies.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of prog_loader_if (byte stream in, imem write port,
//              cpu_hold / done / error status out)
module prog_loader #(
    parameter int unsigned ADDR_W = loader_pkg::ADDR_W,
    parameter int unsigned DATA_W = loader_pkg::DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus
);
    import loader_pkg::*;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        xor_q, xor_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;

    logic              acc;
    logic              load_b0, load_b1;
    logic [DATA_W-1:0] word;
    logic              frame_ok;

    assign acc = bus.byte_valid & ready_q;

    word_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .byte_in  (bus.byte_in),
        .load_b0  (load_b0),
        .load_b1  (load_b1),
        .word     (word),
        .frame_ok (frame_ok)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        xor_d   = xor_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
        hold_d  = hold_q;
        load_b0 = 1'b0;
        load_b1 = 1'b0;

        if (acc) begin
            unique case (state_q)
                HDR0: begin
                    xor_d      = xor_q ^ bus.byte_in;
                    cnt_d[7:0] = bus.byte_in;
                    state_d    = HDR1;
                end
                HDR1: begin
                    // Upper header nibble is ignored but still checksummed.
                    xor_d       = xor_q ^ bus.byte_in;
                    cnt_d[11:8] = bus.byte_in[3:0];
                    state_d     = W0;
                end
                W0: begin
                    xor_d   = xor_q ^ bus.byte_in;
                    load_b0 = 1'b1;
                    state_d = W1;
                end
                W1: begin
                    xor_d   = xor_q ^ bus.byte_in;
                    load_b1 = 1'b1;
                    state_d = W2;
                end
                W2: begin
                    xor_d = xor_q ^ bus.byte_in;
                    if (!frame_ok) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = word;
                        if (cnt_q == '0) begin
                            // Last word: address is left alone so N=4096 never wraps.
                            state_d = CHK;
                        end else begin
                            cnt_d   = cnt_q - 1'b1;
                            addr_d  = addr_q + 1'b1;
                            state_d = W0;
                        end
                    end
                end
                CHK: begin
                    if (bus.byte_in == xor_q) begin
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end
                DONE, ERR: begin
                end
                default: begin
                end
            endcase
        end

        // Registered ready looks ahead at the next state so it drops on entry.
        ready_d = (state_d != DONE) && (state_d != ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HDR0;
            cnt_q   <= '0;
            addr_q  <= '0;
            xor_q   <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            xor_q   <= xor_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.done       = done_q;
    assign bus.error      = err_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that writes the processor's 19-bit instruction memory from a byte stream. It holds the core in reset, accepts a framed image (header, packed words, checksum), and writes each word to sequential instruction addresses from 0. It then releases the core. It sits between the host byte link and the instruction memory write port. The datapath fetches through the read side of the same memory once `cpu_hold` drops.

## Interface
Parameters:
- `ADDR_W`, 12: instruction address width, matching the 12-bit pc.
- `DATA_W`, 19: instruction word width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `byte_in`  in  8  stream byte.
- `byte_valid`  in  1  `byte_in` is valid this cycle.
- `byte_ready`  out  1  loader accepts a byte this cycle; transfer occurs when `byte_valid & byte_ready`.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  DATA_W  write data.
- `cpu_hold`  out  1  keep the processor in reset / pc at 0.
- `done`  out  1  image loaded and verified; sticky.
- `error`  out  1  framing or checksum failure; sticky.

## Operation
- Frame format:
  - Header: `HDR0`, `HDR1`, little-endian 16 bits. Bits [11:0] hold N−1, so N is 1..4096 words. Bits [15:12] are ignored but included in the checksum.
  - Payload: N words, each sent as 3 bytes, little-endian. Word = {b2[2:0], b1, b0}.
  - Trailer: `CHK`, the XOR of every preceding frame byte (header and payload).
- States:
  - `HDR0` → `HDR1` → `W0` → `W1` → `W2`.
  - From `W2`: go to `W0` if more words remain, otherwise to `CHK`.
  - From `CHK`: go to `DONE` if the byte matches the running XOR, otherwise to `ERR`.
- Each state advances only on an accepted byte.
- Framing error: an accepted `W2` byte with bits [7:3] ≠ 0 goes to `ERR` immediately. No write is issued for that word.
- Word counter is 12 bits and loads N−1 from the header. The last word is the one in which the counter = 0.
- Address counter is ADDR_W bits, cleared to 0, and increments after each write. At N = 4096 it is never advanced past 4095.
- Running XOR is 8 bits, cleared on reset, and updated with every accepted byte except `CHK`.
- `DONE` and `ERR` are terminal until `rst`. `byte_ready` is 0 in both; bytes offered there are neither consumed nor acknowledged.

## Timing
- Reset values:
  - `byte_ready` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `cpu_hold` = 1, `done` = 0, `error` = 0.
  - State = `HDR0`, counters cleared.
- `byte_ready` is 1 from the first cycle after `rst` deasserts, and stays 1 in every state except `DONE` and `ERR`. It is registered and never depends combinationally on `byte_valid`.
- Throughput: one byte per cycle, with no bubble between words.
- Write latency: `imem_we` pulses for exactly 1 cycle, in the cycle after the `W2` byte is accepted, with the final `imem_addr` and `imem_wdata`. A new `W0` byte may be accepted in that same cycle.
- `done` rises, and `cpu_hold` falls, in the cycle after `CHK` is accepted with a match. The last write has already completed at least 1 cycle earlier.
- On `ERR`, `error` rises the cycle after the offending byte. `cpu_hold` stays 1.
- `rst` mid-load: state returns to `HDR0` on that edge and any pending `imem_we` is dropped. Memory contents already written are not undone.
- `rst` together with an accepted byte: reset wins and the byte is discarded.

## Structure
- Shared package (`loader_pkg`) holds:
  - `ADDR_W`, `DATA_W`, `BYTES_PER_WORD` = 3.
  - The state enum: `HDR0`, `HDR1`, `W0`, `W1`, `W2`, `CHK`, `DONE`, `ERR`.
  - Word pack function.
- One sub-module, `word_packer`, handles byte-to-19-bit assembly and the b2[7:3] framing check. The top level owns the FSM, counters, XOR and outputs.

## Test plan
- Single word: bytes 00 00 FF FF 07 07 → one `imem_we`, addr 0, data 0x7FFFF; `done` = 1; `cpu_hold` = 0 one cycle after the last byte.
- Two words, back-to-back with `byte_valid` held high: 01 00 45 23 01 00 00 00 66 → writes (0, 0x12345) and (1, 0x00000); `done` = 1.
- Checksum fault: same two-word frame with trailer 67 → no `done`; `error` = 1; `cpu_hold` = 1; `byte_ready` = 0 thereafter.
- Framing fault: header 00 00, payload 01 02 08 → no write; `error` = 1 one cycle after the 08 byte.
- Throttled source: random `byte_valid` gaps on the two-word frame → identical writes and `done`. No byte is double-counted when `byte_valid` stays high while `byte_ready` = 0.
- Mid-load `rst` after 4 bytes, then a full single-word frame → only that frame's write occurs; addr restarts at 0.
